seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV_BITS, default 14: prescaler width; one scan tick every 2^DIV_BITS ck cycles.
REQ-002 ck  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of ck.
REQ-004 wr_en  input  1  write request for a new display value.
REQ-005 wr_data  input  16  four digits, [3:0] = ones (digit0) ... [15:12] = thousands (digit3).
REQ-006 wr_dp  input  4  decimal points; bit n belongs to digit n.
REQ-007 wr_rdy  output  1  high when a write is accepted this cycle.
REQ-008 s  output  4  one-hot digit select, active high; 0001 = digit0 ... 1000 = digit3.
REQ-009 seg  output  8  common-cathode segments {dp,g,f,e,d,c,b,a}; 1 = lit.
REQ-010 frame_done  output  1  one-cycle pulse when a full 4-digit frame completes.

Function
REQ-011 A DIV_BITS-bit counter increments every ck cycle and wraps; tick is asserted for one cycle when the counter is all ones.
REQ-012 The scan FSM has states BLANK, D0, D1, D2, D3; it changes only on tick: BLANK->D0, D0->D1, D1->D2, D2->D3, D3->D0.
REQ-013 s is registered and equals 0000 in BLANK, 0001/0010/0100/1000 in D0/D1/D2/D3, updated on the same edge as the state.
REQ-014 seg is registered on the same edge as s and shows the digit selected by the new s value; seg = 00 in BLANK.
REQ-015 Decode of digit value: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; A-F display dash (g only, 40) in seg[6:0].
REQ-016 seg[7] equals the committed dp bit of the selected digit, independent of seg[6:0].
REQ-017 wr_rdy = NOT pending; a write is accepted when wr_en and wr_rdy are both high: wr_data/wr_dp are captured into a shadow register and pending is set.
REQ-018 wr_en while wr_rdy is low is ignored; shadow is unchanged.
REQ-019 Commit: on a tick leaving D3 or BLANK with pending set, shadow is copied to the display register, pending clears, and the seg driven for D0 on that edge uses the new value (no frame tearing).
REQ-020 A write accepted on the same edge as a commit tick (pending was 0) is not committed on that edge; it commits at the next frame boundary.
REQ-021 frame_done pulses high for exactly the one cycle following the D3->D0 edge; it never pulses on BLANK->D0.
REQ-022 Display register holds its value indefinitely without new writes; the scan runs continuously.

Reset
REQ-023 With rst high at a rising edge: counter=0, state=BLANK, s=0000, seg=00, frame_done=0, pending=0 (wr_rdy=1), shadow and display registers = 0.
REQ-024 rst overrides all other inputs, including wr_en and tick, and takes effect mid-frame.

Configuration
REQ-025 Macro SEG_LEAD_ZERO_BLANK_EN defined: digit3 is blanked if its value is 0; digit2 if digits 3..2 are 0; digit1 if digits 3..1 are 0; digit0 is never blanked; a blanked digit drives seg[6:0]=00 with seg[7] still from dp.
REQ-026 Macro SEG_LEAD_ZERO_BLANK_EN undefined: every digit is decoded per REQ-015; no blanking logic is present.

Verification (DIV_BITS=2, tick every 4 cycles)
REQ-027 rst high 3 cycles -> s=0000, seg=00, wr_rdy=1, frame_done=0 on the cycle after release.
REQ-028 After reset, write 1234/dp 0000 -> successive ticks give s/seg 0001/66, 0010/4F, 0100/5B, 1000/06, then 0001/66 with frame_done high for one cycle.
REQ-029 Write 5678 while in D1 -> wr_rdy low next cycle; second wr_en of 9999 ignored; D3->D0 tick shows seg=7F (digit0=8) and wr_rdy returns high.
REQ-030 Write 00A0/dp 0010 -> digit1 seg=C0 (dash plus dp), digit0 seg=3F.
REQ-031 Write 0007 -> with SEG_LEAD_ZERO_BLANK_EN: digits 3..1 seg=00, digit0 seg=07; without it: digits 3..1 seg=3F.
REQ-032 rst asserted while s=0100 with pending=1 -> next cycle s=0000, seg=00, wr_rdy=1; display reads 0000 on subsequent frame.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered display value.
// Define SEG_LEAD_ZERO_BLANK_EN to blank leading zero digits (digit0 is always shown).
module seg_scan_ctrl #(
    parameter int DIV_BITS = 14
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic        wr_rdy,
    output logic [3:0]  s,
    output logic [7:0]  seg,
    output logic        frame_done
);

    typedef enum logic [2:0] {BLANK, D0, D1, D2, D3} state_t;

    state_t                state_q, state_d;
    logic [DIV_BITS-1:0]   cnt_q;
    logic                  pending_q, pending_d;
    logic [15:0]           shadow_q, shadow_d;
    logic [3:0]            shadowDp_q, shadowDp_d;
    logic [15:0]           disp_q, disp_d;
    logic [3:0]            dispDp_q, dispDp_d;
    logic [3:0]            s_q, s_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frameDone_q, frameDone_d;
    logic                  tick;
    logic [1:0]            idx;
    logic [3:0]            digit;
    logic [6:0]            glyph;
    logic                  blank;

    function automatic logic [6:0] decode7(input logic [3:0] v);
        case (v)
            4'd0:    decode7 = 7'h3F;
            4'd1:    decode7 = 7'h06;
            4'd2:    decode7 = 7'h5B;
            4'd3:    decode7 = 7'h4F;
            4'd4:    decode7 = 7'h66;
            4'd5:    decode7 = 7'h6D;
            4'd6:    decode7 = 7'h7D;
            4'd7:    decode7 = 7'h07;
            4'd8:    decode7 = 7'h7F;
            4'd9:    decode7 = 7'h6F;
            default: decode7 = 7'h40;
        endcase
    endfunction

    assign tick       = &cnt_q;
    assign wr_rdy     = ~pending_q;
    assign s          = s_q;
    assign seg        = seg_q;
    assign frame_done = frameDone_q;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        shadow_d    = shadow_q;
        shadowDp_d  = shadowDp_q;
        disp_d      = disp_q;
        dispDp_d    = dispDp_q;
        s_d         = s_q;
        seg_d       = seg_q;
        frameDone_d = tick && (state_q == D3);
        idx         = 2'd0;
        digit       = 4'd0;
        glyph       = 7'd0;
        blank       = 1'b0;

        // Commit only at a frame boundary so the new value appears starting at digit0.
        if (tick && pending_q && (state_q == D3 || state_q == BLANK)) begin
            disp_d    = shadow_q;
            dispDp_d  = shadowDp_q;
            pending_d = 1'b0;
        end

        if (wr_en && !pending_q) begin
            shadow_d   = wr_data;
            shadowDp_d = wr_dp;
            pending_d  = 1'b1;
        end

        if (tick) begin
            case (state_q)
                D0:      begin state_d = D1; idx = 2'd1; end
                D1:      begin state_d = D2; idx = 2'd2; end
                D2:      begin state_d = D3; idx = 2'd3; end
                default: begin state_d = D0; idx = 2'd0; end
            endcase
            digit = disp_d[{idx, 2'b00} +: 4];
            glyph = decode7(digit);
`ifdef SEG_LEAD_ZERO_BLANK_EN
            case (idx)
                2'd3:    blank = (disp_d[15:12] == 4'd0);
                2'd2:    blank = (disp_d[15:8] == 8'd0);
                2'd1:    blank = (disp_d[15:4] == 12'd0);
                default: blank = 1'b0;
            endcase
`else
            blank = 1'b0;
`endif
            s_d   = 4'b0001 << idx;
            seg_d = {dispDp_d[idx], blank ? 7'd0 : glyph};
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            cnt_q       <= '0;
            state_q     <= BLANK;
            pending_q   <= 1'b0;
            shadow_q    <= 16'd0;
            shadowDp_q  <= 4'd0;
            disp_q      <= 16'd0;
            dispDp_q    <= 4'd0;
            s_q         <= 4'd0;
            seg_q       <= 8'd0;
            frameDone_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_q + {{(DIV_BITS-1){1'b0}}, 1'b1};
            state_q     <= state_d;
            pending_q   <= pending_d;
            shadow_q    <= shadow_d;
            shadowDp_q  <= shadowDp_d;
            disp_q      <= disp_d;
            dispDp_q    <= dispDp_d;
            s_q         <= s_d;
            seg_q       <= seg_d;
            frameDone_q <= frameDone_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a fast prescaler; a frame-level model tracks every cycle.
module tb_seg_scan_ctrl;

    localparam int DIV = 2;

`ifdef SEG_LEAD_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        ck;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic        wr_rdy;
    logic [3:0]  s;
    logic [7:0]  seg;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: position in the frame (-1 blank, 0..3 digit) plus buffered values.
    int          mCnt;
    int          mPos;
    logic        mPend;
    logic [15:0] mShadow, mDisp;
    logic [3:0]  mShadowDp, mDispDp;
    logic [3:0]  mS;
    logic [7:0]  mSeg;
    logic        mFd;
    logic [6:0]  segTable [16];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [31:0] expPlain;
        logic [31:0] expBlank;
    } vec_t;

    vec_t vecs [6];

    seg_scan_ctrl #(.DIV_BITS(DIV)) dut (
        .ck(ck),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_dp(wr_dp),
        .wr_rdy(wr_rdy),
        .s(s),
        .seg(seg),
        .frame_done(frame_done)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] refSeg(input logic [15:0] v, input logic [3:0] dp, input int pos);
        int         d;
        logic [6:0] code;
        d    = int'((v >> (4 * pos)) & 16'hF);
        code = segTable[d];
        if (BLANK_EN && pos != 0 && (v >> (4 * pos)) == 16'd0)
            code = 7'd0;
        return {dp[pos], code};
    endfunction

    task automatic modelEdge(input logic r, input logic we, input logic [15:0] d, input logic [3:0] dp);
        bit tick;
        bit accept;
        if (r) begin
            mCnt = 0; mPos = -1; mPend = 1'b0;
            mShadow = 16'd0; mShadowDp = 4'd0; mDisp = 16'd0; mDispDp = 4'd0;
            mS = 4'd0; mSeg = 8'd0; mFd = 1'b0;
        end else begin
            tick   = (mCnt == (1 << DIV) - 1);
            accept = we && !mPend;
            mFd    = tick && (mPos == 3);
            if (tick) begin
                if ((mPos == -1 || mPos == 3) && mPend) begin
                    mDisp   = mShadow;
                    mDispDp = mShadowDp;
                    mPend   = 1'b0;
                end
                mPos = (mPos + 1) % 4;
                mS   = 4'(1 << mPos);
                mSeg = refSeg(mDisp, mDispDp, mPos);
            end
            if (accept) begin
                mShadow   = d;
                mShadowDp = dp;
                mPend     = 1'b1;
            end
            mCnt = (mCnt + 1) % (1 << DIV);
        end
    endtask

    task automatic checkOne(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkOne("s", 16'(s), 16'(mS));
        checkOne("seg", 16'(seg), 16'(mSeg));
        checkOne("frame_done", 16'(frame_done), 16'(mFd));
        checkOne("wr_rdy", 16'(wr_rdy), 16'(!mPend));
    endtask

    task automatic applyStimulus(input logic r, input logic we, input logic [15:0] d, input logic [3:0] dp);
        rst     = r;
        wr_en   = we;
        wr_data = d;
        wr_dp   = dp;
        @(posedge ck);
        modelEdge(r, we, d, dp);
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s timeout actual=none required=event", name);
    endtask

    task automatic waitTick();
        logic [3:0] prev;
        prev = s;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (s !== prev) return;
        end
        timeoutFail("wait_tick");
    endtask

    task automatic waitFrame();
        for (int i = 0; i < 40; i++) begin
            idle();
            if (frame_done === 1'b1) return;
        end
        timeoutFail("wait_frame");
    endtask

    task automatic waitSel(input logic [3:0] want);
        for (int i = 0; i < 40; i++) begin
            if (s === want) return;
            idle();
        end
        timeoutFail("wait_sel");
    endtask

    logic [3:0]  seqS   [5];
    logic [7:0]  seqSeg [5];
    logic [31:0] expAll;
    logic [7:0]  zeroOther;

    initial begin
        segTable = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                     7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        vecs[0] = '{16'h1234, 4'b0000, 32'h065B4F66, 32'h065B4F66};
        vecs[1] = '{16'h00A0, 4'b0010, 32'h3F3FC03F, 32'h0000C03F};
        vecs[2] = '{16'h0007, 4'b0000, 32'h3F3F3F07, 32'h00000007};
        vecs[3] = '{16'h5678, 4'b1111, 32'hEDFD87FF, 32'hEDFD87FF};
        vecs[4] = '{16'hFE09, 4'b1000, 32'hC0403F6F, 32'hC0403F6F};
        vecs[5] = '{16'h0100, 4'b0001, 32'h3F063FBF, 32'h00063FBF};
        seqS    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seqSeg  = '{8'h66, 8'h4F, 8'h5B, 8'h06, 8'h66};
        rst = 1'b1; wr_en = 1'b0; wr_data = 16'd0; wr_dp = 4'd0;
        mCnt = 0; mPos = -1; mPend = 1'b0; mShadow = 16'd0; mShadowDp = 4'd0;
        mDisp = 16'd0; mDispDp = 4'd0; mS = 4'd0; mSeg = 8'd0; mFd = 1'b0;

        // Reset held three cycles, with a write request that must be ignored.
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 4'hF);
        applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
        idle();
        checkOne("rst_s", 16'(s), 16'h0);
        checkOne("rst_seg", 16'(seg), 16'h0);
        checkOne("rst_wr_rdy", 16'(wr_rdy), 16'h1);
        checkOne("rst_frame_done", 16'(frame_done), 16'h0);

        // First frame after reset shows 1234; frame_done only after D3->D0.
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            waitTick();
            checkOne("seq_s", 16'(s), 16'(seqS[k]));
            checkOne("seq_seg", 16'(seg), 16'(seqSeg[k]));
            checkOne("seq_frame_done", 16'(frame_done), (k == 4) ? 16'h1 : 16'h0);
        end
        idle();
        checkOne("frame_done_one_cycle", 16'(frame_done), 16'h0);

        // Table of display values, each checked across one full frame after commit.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(1'b0, 1'b1, vecs[v].data, vecs[v].dp);
            waitFrame();
            expAll = BLANK_EN ? vecs[v].expBlank : vecs[v].expPlain;
            for (int d = 0; d < 4; d++) begin
                if (d > 0) waitTick();
                checkOne("vec_sel", 16'(s), 16'(4'b0001 << d));
                checkOne("vec_seg", 16'(seg), 16'(expAll[8*d +: 8]));
            end
        end

        // Write during D1 holds off a second write until the frame boundary commit.
        waitSel(4'b0010);
        applyStimulus(1'b0, 1'b1, 16'h5678, 4'b0000);
        checkOne("busy_wr_rdy", 16'(wr_rdy), 16'h0);
        applyStimulus(1'b0, 1'b1, 16'h9999, 4'b0000);
        waitFrame();
        checkOne("commit_seg0", 16'(seg), 16'h7F);
        checkOne("commit_wr_rdy", 16'(wr_rdy), 16'h1);
        waitTick();
        checkOne("commit_seg1", 16'(seg), 16'h07);
        waitTick();
        waitTick();
        checkOne("commit_seg3", 16'(seg), 16'h6D);

        // Reset mid-frame while a write is still pending.
        waitSel(4'b0010);
        applyStimulus(1'b0, 1'b1, 16'h4321, 4'b1111);
        waitSel(4'b0100);
        applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
        checkOne("midrst_s", 16'(s), 16'h0);
        checkOne("midrst_seg", 16'(seg), 16'h0);
        checkOne("midrst_wr_rdy", 16'(wr_rdy), 16'h1);
        zeroOther = BLANK_EN ? 8'h00 : 8'h3F;
        for (int d = 0; d < 4; d++) begin
            waitTick();
            checkOne("midrst_disp", 16'(seg), (d == 0) ? 16'h3F : 16'(zeroOther));
        end

        // Randomized traffic, including occasional resets, against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                          16'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
